// File: rtl/wave_cfg_pkg.sv
// Shared types for the waveform configuration controller: waveform select,
// 18-bit config frame layout and controller FSM states.
package wave_cfg_pkg;

    typedef enum logic [1:0] {
        SINE     = 2'd0,
        SQUARE   = 2'd1,
        TRIANGLE = 2'd2,
        SAW      = 2'd3
    } wave_t;

    // Field order matches the frame: [17:2] divider, [1:0] waveform select.
    typedef struct packed {
        logic [15:0] divider;
        wave_t       wave;
    } cfg_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        MUTE    = 2'd2
    } state_t;

    localparam int unsigned FRAME_W = 18;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wave_cfg_ctrl_if.sv
// Bus between the SPI frame receiver / waveform generator side (master) and
// the configuration controller (slave).
interface wave_cfg_ctrl_if;
    import wave_cfg_pkg::*;

    logic [FRAME_W-1:0] frame_data;
    logic               frame_valid;
    logic               period_tick;
    logic               gen_enable;
    logic [15:0]        divider;
    logic [1:0]         wave_sel;
    logic               cfg_update;
    logic               mute;
    logic               busy;
    logic [7:0]         reject_cnt;

    modport master (
        output frame_data, frame_valid, period_tick, gen_enable,
        input  divider, wave_sel, cfg_update, mute, busy, reject_cnt
    );

    modport slave (
        input  frame_data, frame_valid, period_tick, gen_enable,
        output divider, wave_sel, cfg_update, mute, busy, reject_cnt
    );

endinterface

// File: rtl/wave_cfg_ctrl.sv
// Range-checks incoming config frames, shadows the latest one and applies it at a
// waveform period boundary, muting the generator across waveform-type changes.
module wave_cfg_ctrl
    import wave_cfg_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV    = 16'd1000,
    parameter logic [15:0] MIN_DIV        = 16'd4,
    parameter int unsigned MUTE_CYCLES    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic            clk,
    input  logic            rst,
    wave_cfg_ctrl_if.slave  cfg_bus
);

    localparam int unsigned TO_W   = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned MUTE_W = cnt_width(MUTE_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [MUTE_W-1:0] MUTE_LAST = MUTE_W'(MUTE_CYCLES - 1);
    localparam cfg_t RESET_CFG = '{divider: DEFAULT_DIV, wave: SINE};

    state_t            r_state,    w_state;
    cfg_t              r_active,   w_active;
    cfg_t              r_shadow,   w_shadow;
    logic [TO_W-1:0]   r_to_cnt,   w_to_cnt;
    logic [MUTE_W-1:0] r_mute_cnt, w_mute_cnt;
    logic              r_mute,     w_mute;
    logic              r_cfg_update, w_cfg_update;
    logic [7:0]        r_reject_cnt, w_reject_cnt;

    cfg_t w_frame;
    logic w_frame_ok;
    logic w_frame_bad;
    logic w_trigger;
    logic w_apply;

    assign w_frame     = cfg_t'(cfg_bus.frame_data);
    assign w_frame_ok  = cfg_bus.frame_valid && (w_frame.divider >= MIN_DIV);
    assign w_frame_bad = cfg_bus.frame_valid && (w_frame.divider < MIN_DIV);
    assign w_trigger   = cfg_bus.period_tick || !cfg_bus.gen_enable || (r_to_cnt == TO_LAST);

    always_comb begin
        w_state      = r_state;
        w_active     = r_active;
        w_to_cnt     = r_to_cnt;
        w_mute_cnt   = r_mute_cnt;
        w_mute       = r_mute;
        w_cfg_update = 1'b0;
        w_apply      = 1'b0;

        w_shadow     = w_frame_ok ? w_frame : r_shadow;
        w_reject_cnt = (w_frame_bad && (r_reject_cnt != 8'hFF)) ? r_reject_cnt + 8'd1
                                                                : r_reject_cnt;

        unique case (r_state)
            IDLE: begin
                if (w_frame_ok && (w_frame != r_active)) begin
                    w_state  = PENDING;
                    w_to_cnt = '0;
                end
            end
            PENDING: begin
                if (w_trigger) begin
                    if (r_shadow.wave == r_active.wave) begin
                        w_apply = 1'b1;
                    end else begin
                        w_state    = MUTE;
                        w_mute     = 1'b1;
                        w_mute_cnt = '0;
                    end
                end else begin
                    w_to_cnt = r_to_cnt + 1'b1;
                end
            end
            MUTE: begin
                if (r_mute_cnt == MUTE_LAST) begin
                    w_mute  = 1'b0;
                    w_apply = 1'b1;
                end else begin
                    w_mute_cnt = r_mute_cnt + 1'b1;
                end
            end
            default: w_state = IDLE;
        endcase

        // Apply the registered shadow; a frame landing on this edge re-arms PENDING.
        if (w_apply) begin
            w_active     = r_shadow;
            w_cfg_update = 1'b1;
            if (w_frame_ok && (w_frame != r_shadow)) begin
                w_state  = PENDING;
                w_to_cnt = '0;
            end else begin
                w_state = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_active     <= RESET_CFG;
            r_shadow     <= RESET_CFG;
            r_to_cnt     <= '0;
            r_mute_cnt   <= '0;
            r_mute       <= 1'b0;
            r_cfg_update <= 1'b0;
            r_reject_cnt <= 8'd0;
        end else begin
            r_state      <= w_state;
            r_active     <= w_active;
            r_shadow     <= w_shadow;
            r_to_cnt     <= w_to_cnt;
            r_mute_cnt   <= w_mute_cnt;
            r_mute       <= w_mute;
            r_cfg_update <= w_cfg_update;
            r_reject_cnt <= w_reject_cnt;
        end
    end

    assign cfg_bus.divider    = r_active.divider;
    assign cfg_bus.wave_sel   = r_active.wave;
    assign cfg_bus.cfg_update = r_cfg_update;
    assign cfg_bus.mute       = r_mute;
    assign cfg_bus.busy       = (r_state != IDLE);
    assign cfg_bus.reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_wave_cfg_ctrl.sv
// Directed bench for wave_cfg_ctrl; the timeout is shortened to keep the run brief.
module tb_wave_cfg_ctrl;

    localparam int unsigned TB_TIMEOUT = 1000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   nb, nm, nu;

    wave_cfg_ctrl_if bus_if ();

    wave_cfg_ctrl #(
        .DEFAULT_DIV    (16'd1000),
        .MIN_DIV        (16'd4),
        .MUTE_CYCLES    (16),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] div, input logic [1:0] wave);
        bus_if.frame_data  = {div, wave};
        bus_if.frame_valid = 1'b1;
        tick();
        bus_if.frame_valid = 1'b0;
    endtask

    task automatic pulse_tick();
        bus_if.period_tick = 1'b1;
        tick();
        bus_if.period_tick = 1'b0;
    endtask

    // Counts high samples of busy / mute / cfg_update over n cycles.
    task automatic run_count(input int n, output int b, output int m, output int u);
        b = 0; m = 0; u = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            b += int'(bus_if.busy);
            m += int'(bus_if.mute);
            u += int'(bus_if.cfg_update);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus_if.frame_data  = '0;
        bus_if.frame_valid = 1'b0;
        bus_if.period_tick = 1'b0;
        bus_if.gen_enable  = 1'b1;
        #2;
        check_val("rst_div",    bus_if.divider, 1000);
        check_val("rst_wave",   bus_if.wave_sel, 0);
        check_val("rst_upd",    bus_if.cfg_update, 0);
        check_val("rst_mute",   bus_if.mute, 0);
        check_val("rst_busy",   bus_if.busy, 0);
        check_val("rst_reject", bus_if.reject_cnt, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Same-wave apply on the tick edge
        send(16'd2000, 2'd0);
        check_val("t1_busy_entry", bus_if.busy, 1);
        run_count(4, nb, nm, nu);
        pulse_tick();
        check_val("t1_div",       bus_if.divider, 2000);
        check_val("t1_upd",       bus_if.cfg_update, 1);
        check_val("t1_busy_off",  bus_if.busy, 0);
        check_val("t1_busy_cyc",  1 + nb, 5);
        check_val("t1_mute_seen", nm + int'(bus_if.mute), 0);
        tick();
        check_val("t1_upd_fall",  bus_if.cfg_update, 0);

        // Rejections and saturation
        send(16'd3, 2'd0);
        check_val("t2_reject1", bus_if.reject_cnt, 1);
        check_val("t2_busy",    bus_if.busy, 0);
        bus_if.frame_data  = '0;
        bus_if.frame_valid = 1'b1;
        repeat (300) tick();
        bus_if.frame_valid = 1'b0;
        check_val("t2_sat",     bus_if.reject_cnt, 255);
        check_val("t2_div",     bus_if.divider, 2000);

        // Wave change goes through 16 cycles of mute
        send(16'd500, 2'd2);
        pulse_tick();
        check_val("t3_mute_on",  bus_if.mute, 1);
        check_val("t3_div_hold", bus_if.divider, 2000);
        run_count(15, nb, nm, nu);
        check_val("t3_mute_cyc", nm, 15);
        check_val("t3_upd_early", nu, 0);
        tick();
        check_val("t3_mute_off", bus_if.mute, 0);
        check_val("t3_div",      bus_if.divider, 500);
        check_val("t3_wave",     bus_if.wave_sel, 2);
        check_val("t3_upd",      bus_if.cfg_update, 1);
        run_count(5, nb, nm, nu);
        check_val("t3_upd_once", nu, 0);

        // Last pending frame wins
        send(16'd800, 2'd2);
        send(16'd900, 2'd2);
        check_val("t4_div_hold", bus_if.divider, 500);
        pulse_tick();
        check_val("t4_div",      bus_if.divider, 900);
        check_val("t4_upd",      bus_if.cfg_update, 1);
        run_count(5, nb, nm, nu);
        check_val("t4_upd_once", nu, 0);

        // Frame received during mute is the one applied
        send(16'd900, 2'd3);
        pulse_tick();
        check_val("t4m_mute_on", bus_if.mute, 1);
        run_count(3, nb, nm, nu);
        send(16'd700, 2'd1);
        run_count(11, nb, nm, nu);
        check_val("t4m_mute_cyc", nm, 11);
        tick();
        check_val("t4m_wave",    bus_if.wave_sel, 1);
        check_val("t4m_div",     bus_if.divider, 700);
        check_val("t4m_mute",    bus_if.mute, 0);
        check_val("t4m_upd",     bus_if.cfg_update, 1);
        check_val("t4m_busy",    bus_if.busy, 0);

        // Frame on the apply edge re-arms PENDING
        send(16'd600, 2'd1);
        bus_if.period_tick = 1'b1;
        send(16'd650, 2'd1);
        bus_if.period_tick = 1'b0;
        check_val("ae_div_old",  bus_if.divider, 600);
        check_val("ae_busy",     bus_if.busy, 1);
        pulse_tick();
        check_val("ae_div_new",  bus_if.divider, 650);
        tick();

        // Frame equal to active config in IDLE is dropped
        send(16'd650, 2'd1);
        check_val("eq_busy",     bus_if.busy, 0);
        check_val("eq_upd",      bus_if.cfg_update, 0);

        // Generator stopped: apply on the next edge
        bus_if.gen_enable = 1'b0;
        send(16'd1234, 2'd1);
        check_val("ge_div_hold", bus_if.divider, 650);
        check_val("ge_busy",     bus_if.busy, 1);
        tick();
        check_val("ge_div",      bus_if.divider, 1234);
        check_val("ge_upd",      bus_if.cfg_update, 1);
        bus_if.gen_enable = 1'b1;

        // Forced apply after the timeout; divider 4 is the smallest legal value
        send(16'd4, 2'd1);
        run_count(TB_TIMEOUT - 1, nb, nm, nu);
        check_val("to_busy_cyc", nb, TB_TIMEOUT - 1);
        check_val("to_upd_early", nu, 0);
        tick();
        check_val("to_div",      bus_if.divider, 4);
        check_val("to_upd",      bus_if.cfg_update, 1);
        check_val("to_busy",     bus_if.busy, 0);
        check_val("to_reject",   bus_if.reject_cnt, 255);

        // Asynchronous reset in the middle of mute
        send(16'd1500, 2'd3);
        pulse_tick();
        run_count(3, nb, nm, nu);
        check_val("ar_pre_mute", bus_if.mute, 1);
        #1 rst = 1'b1;
        #1;
        check_val("ar_mute",     bus_if.mute, 0);
        check_val("ar_div",      bus_if.divider, 1000);
        check_val("ar_wave",     bus_if.wave_sel, 0);
        check_val("ar_busy",     bus_if.busy, 0);
        tick();
        rst = 1'b0;
        run_count(20, nb, nm, nu);
        check_val("ar_post_busy", nb, 0);
        check_val("ar_post_div",  bus_if.divider, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_cfg_ctrl.md
Name: wave_cfg_ctrl

Overview:
- Configuration controller between the SPI frame receiver and the waveform generator.
- Accepts 18-bit config frames (16-bit divider plus 2-bit waveform select) and range-checks them.
- Holds the latest valid frame in a shadow register.
- Applies it glitch-free at a waveform period boundary, muting the output across waveform-type changes.

Parameters:
- DEFAULT_DIV, 16'd1000, divider value loaded at reset.
- MIN_DIV, 16'd4, smallest legal divider; smaller frames are rejected.
- MUTE_CYCLES, 16, cycles mute is held high before a waveform-type switch.
- TIMEOUT_CYCLES, 100000, maximum cycles spent waiting for period_tick before a forced apply.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_data  in  18  received frame; [17:2] divider, [1:0] waveform select
- frame_valid  in  1  one-cycle strobe, frame_data valid
- period_tick  in  1  one-cycle strobe from generator at phase wrap
- gen_enable  in  1  generator running; when low, boundaries are not awaited
- divider  out  16  active divider
- wave_sel  out  2  active waveform select
- cfg_update  out  1  one-cycle pulse when active config changes
- mute  out  1  generator output forced to midscale while high
- busy  out  1  high in any state other than IDLE
- reject_cnt  out  8  saturating count of rejected frames

Behaviour:
- Reset (async, immediate):
  - divider=DEFAULT_DIV, wave_sel=0, cfg_update=0, mute=0, busy=0, reject_cnt=0.
  - shadow=active, state=IDLE, timers cleared.
  - Reset mid-mute or mid-pending discards the shadow.
- Frame intake, every cycle, independent of state:
  - frame_valid with divider field < MIN_DIV: reject_cnt+1, saturating at 255; nothing else changes.
  - Valid frame: shadow <= frame; last frame wins, earlier pending frames are silently replaced.
  - Valid frame equal to active config while state is IDLE: dropped; no transition, no cfg_update.
  - Other valid frames in IDLE: state goes to PENDING next edge, and the timeout counter is cleared.
- PENDING: waits for a trigger, evaluated each edge. A trigger is any of:
  - period_tick=1
  - gen_enable=0
  - timeout counter == TIMEOUT_CYCLES-1
- Trigger with shadow.wave == wave_sel:
  - divider and wave_sel load from shadow on that same edge.
  - cfg_update=1 for the following cycle; next state IDLE.
  - Latency: 0 edges from trigger sample to new outputs.
- Trigger with shadow.wave != wave_sel:
  - Go to MUTE; mute=1 from that edge; mute counter cleared.
- MUTE:
  - Counts MUTE_CYCLES cycles.
  - On the edge where the count == MUTE_CYCLES-1: mute=0, divider and wave_sel load from the current shadow (including frames received during mute), cfg_update pulses 1 cycle, next state IDLE.
  - period_tick is ignored in MUTE.
- Frame arriving on the apply edge:
  - The apply uses the old shadow; the new frame is latched.
  - Next state is PENDING instead of IDLE, unless the new frame equals the config just applied, in which case IDLE.
- busy = (state != IDLE).
- Timeout counter:
  - Increments only in PENDING; cleared on entry to PENDING.
  - Width $clog2(TIMEOUT_CYCLES).
- frame_valid and period_tick on the same edge while in IDLE: the frame only moves to PENDING; the tick is not consumed.

Decomposition:
- Package wave_cfg_pkg holds:
  - wave_t enum: SINE=0, SQUARE=1, TRIANGLE=2, SAW=3.
  - cfg_t packed struct {divider[15:0], wave_t wave}, bit-compatible with the 18-bit frame.
  - state_t enum {IDLE, PENDING, MUTE}.
- No sub-module; a single FSM with shadow/active registers and two counters.

Test Plan:
- Reset, then frame div=2000 wave=0, period_tick 5 cycles later -> divider=2000 on the tick edge, cfg_update pulse 1 cycle, mute never high, busy high for 5 cycles.
- Frame div=3 -> reject_cnt=1, busy stays 0. Then 300 frames with div=0 -> reject_cnt saturates at 255.
- Frame div=500 wave=2 from active wave=0, then tick:
  - mute high exactly 16 cycles.
  - divider=500 and wave_sel=2 on the edge mute falls, cfg_update pulses once.
- Two frames (div=800, then div=900) before the tick -> one cfg_update only, divider=900. A frame wave=1 during MUTE -> wave_sel=1 at mute end.
- gen_enable=0 with a frame pending -> applied on the next edge. With gen_enable=1 and no tick -> forced apply after exactly 100000 cycles in PENDING.
- Assert rst 3 cycles into MUTE -> mute=0, divider=1000, wave_sel=0, busy=0 immediately, before the next clock edge.
